// File: rtl/apb_master_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_ctrl_pkg
//  Description : Shared types and defaults for the APB3 requester: FSM state
//                encoding, default bus widths and wait-counter sizing helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_master_ctrl_pkg;

    localparam int c_ADDR_W_DEF  = 8;
    localparam int c_DATA_W_DEF  = 32;
    localparam int c_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Wait counter must hold the value TIMEOUT itself; keep at least one bit
    // so that TIMEOUT=0 (wait forever) still yields a legal vector.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_master_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_ctrl_if
//  Description : Command/response port plus APB3 requester bus. The master
//                modport is the controller's view; slave is the view of the
//                environment (command source and APB completer).
//  Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();
    // command / response side
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    // APB side
    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_ctrl
//  Description : APB3 requester. Turns valid/ready commands into SETUP/ACCESS
//                transfers, returns one response pulse per command and aborts
//                a stalled completer after TIMEOUT wait cycles (0 = never).
//                Every output is driven straight from a flop.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master_ctrl
    import apb_master_ctrl_pkg::*;
#(
    parameter int ADDR_W  = c_ADDR_W_DEF,
    parameter int DATA_W  = c_DATA_W_DEF,
    parameter int TIMEOUT = c_TIMEOUT_DEF
) (
    input  wire logic        PCLK,
    input  wire logic        PRESETn,
    apb_master_ctrl_if.master bus
);

    localparam int               c_CNT_W     = cnt_width(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LIMIT = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = {c_CNT_W{1'b1}};
    localparam logic             c_TMO_EN    = (TIMEOUT != 0);

    state_t              r_state,     w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt,       w_cnt_nxt;
    logic                r_cmd_ready, w_cmd_ready_nxt;
    logic                r_psel,      w_psel_nxt;
    logic                r_penable,   w_penable_nxt;
    logic                r_pwrite,    w_pwrite_nxt;
    logic [ADDR_W-1:0]   r_paddr,     w_paddr_nxt;
    logic [DATA_W-1:0]   r_pwdata,    w_pwdata_nxt;
    logic                r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
    logic                r_rsp_err,   w_rsp_err_nxt;
    logic                w_timeout;

    assign w_timeout = c_TMO_EN && (r_cnt == c_CNT_LIMIT);

    // Next-state and next-output decode; everything holds unless a transition
    // says otherwise, rsp_valid defaults low so it can only pulse.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_cmd_ready_nxt = r_cmd_ready;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;
        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid && r_cmd_ready) begin
                    w_state_nxt     = ST_SETUP;
                    w_cnt_nxt       = '0;
                    w_cmd_ready_nxt = 1'b0;
                    w_psel_nxt      = 1'b1;
                    w_penable_nxt   = 1'b0;
                    w_pwrite_nxt    = bus.cmd_write;
                    w_paddr_nxt     = bus.cmd_addr;
                    w_pwdata_nxt    = bus.cmd_wdata;
                end
            end
            ST_SETUP: begin
                w_state_nxt   = ST_ACCESS;
                w_penable_nxt = 1'b1;
            end
            ST_ACCESS: begin
                // A ready completer wins over a timeout landing in the same cycle.
                if (bus.PREADY) begin
                    w_state_nxt     = ST_IDLE;
                    w_cmd_ready_nxt = 1'b1;
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = bus.PSLVERR;
                    w_rsp_rdata_nxt = r_pwrite ? '0 : bus.PRDATA;
                end else if (w_timeout) begin
                    w_state_nxt     = ST_IDLE;
                    w_cmd_ready_nxt = 1'b1;
                    w_psel_nxt      = 1'b0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                end else if (r_cnt != c_CNT_MAX) begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_cmd_ready_nxt = 1'b1;
                w_psel_nxt      = 1'b0;
                w_penable_nxt   = 1'b0;
            end
        endcase
    end

    // State and output registers; asynchronous reset returns the bus to idle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.PSEL      = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master_ctrl
//  Description : Directed bench for apb_master_ctrl (TIMEOUT=4) with a small
//                LED/SW completer model: write, read, wait states with error,
//                timeout abort, ready-at-limit, back-to-back, reset mid-access.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_ctrl;

    logic        PCLK    = 1'b0;
    logic        PRESETn = 1'b0;
    logic        tb_pready  = 1'b1;
    logic        tb_pslverr = 1'b0;
    logic [31:0] sw  = 32'h0000_1234;
    logic [31:0] led = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    apb_master_ctrl_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    apb_master_ctrl #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(4)) u_dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    // Completer model: LED register at 0x00, switch input readable at 0x04.
    assign bus.PREADY  = tb_pready;
    assign bus.PSLVERR = tb_pslverr;
    assign bus.PRDATA  = (bus.PADDR == 8'h04) ? sw : ((bus.PADDR == 8'h00) ? led : 32'h0);

    // LED register updates on a completed write access.
    always @(posedge PCLK) begin
        if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE && bus.PADDR == 8'h00)
            led <= bus.PWDATA;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d);
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_valid = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc_cyc[3];
        int rsp_cyc[3];
        int k;
        int n_rsp;
        logic will_acc;

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h00;
        bus.cmd_wdata = 32'h0;

        // ---------------- reset state ----------------
        step();
        step();
        check_val("rst_psel",    bus.PSEL,      0);
        check_val("rst_penable", bus.PENABLE,   0);
        check_val("rst_pwrite",  bus.PWRITE,    0);
        check_val("rst_paddr",   bus.PADDR,     0);
        check_val("rst_pwdata",  bus.PWDATA,    0);
        check_val("rst_rspv",    bus.rsp_valid, 0);
        check_val("rst_rdata",   bus.rsp_rdata, 0);
        check_val("rst_err",     bus.rsp_err,   0);
        PRESETn = 1'b1;
        step();
        check_val("rel_ready",   bus.cmd_ready, 1);

        // ---------------- zero-wait write ----------------
        issue(1'b1, 8'h00, 32'h0000_A5A5);
        step();
        bus.cmd_valid = 1'b0;
        check_val("wr_n1_psel",    bus.PSEL,      1);
        check_val("wr_n1_penable", bus.PENABLE,   0);
        check_val("wr_n1_ready",   bus.cmd_ready, 0);
        check_val("wr_n1_paddr",   bus.PADDR,     32'h00);
        check_val("wr_n1_pwdata",  bus.PWDATA,    32'h0000_A5A5);
        check_val("wr_n1_pwrite",  bus.PWRITE,    1);
        step();
        check_val("wr_n2_psel",    bus.PSEL,      1);
        check_val("wr_n2_penable", bus.PENABLE,   1);
        check_val("wr_n2_rspv",    bus.rsp_valid, 0);
        step();
        check_val("wr_n3_rspv",    bus.rsp_valid, 1);
        check_val("wr_n3_err",     bus.rsp_err,   0);
        check_val("wr_n3_rdata",   bus.rsp_rdata, 0);
        check_val("wr_n3_psel",    bus.PSEL,      0);
        check_val("wr_n3_penable", bus.PENABLE,   0);
        check_val("wr_n3_ready",   bus.cmd_ready, 1);
        check_val("wr_led",        led,           32'h0000_A5A5);
        step();
        check_val("wr_n4_rspv",    bus.rsp_valid, 0);
        check_val("idle_paddr",    bus.PADDR,     32'h00);
        check_val("idle_pwdata",   bus.PWDATA,    32'h0000_A5A5);

        // ---------------- zero-wait read of switches ----------------
        issue(1'b0, 8'h04, 32'hFFFF_FFFF);
        step();
        bus.cmd_valid = 1'b0;
        check_val("rd_n1_ready",  bus.cmd_ready, 0);
        check_val("rd_n1_pwrite", bus.PWRITE,    0);
        check_val("rd_n1_paddr",  bus.PADDR,     32'h04);
        step();
        check_val("rd_n2_ready",  bus.cmd_ready, 0);
        check_val("rd_n2_penable", bus.PENABLE,  1);
        step();
        check_val("rd_n3_rspv",   bus.rsp_valid, 1);
        check_val("rd_n3_rdata",  bus.rsp_rdata, 32'h0000_1234);
        check_val("rd_n3_err",    bus.rsp_err,   0);

        // ---------------- wait states then error ----------------
        issue(1'b1, 8'h08, 32'hDEAD_BEEF);
        step();
        bus.cmd_valid = 1'b0;
        tb_pready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("ws_psel",    bus.PSEL,      1);
            check_val("ws_penable", bus.PENABLE,   1);
            check_val("ws_paddr",   bus.PADDR,     32'h08);
            check_val("ws_pwdata",  bus.PWDATA,    32'hDEAD_BEEF);
            check_val("ws_pwrite",  bus.PWRITE,    1);
            check_val("ws_rspv",    bus.rsp_valid, 0);
        end
        tb_pready  = 1'b1;
        tb_pslverr = 1'b1;
        step();
        tb_pslverr = 1'b0;
        check_val("ws_n6_rspv",  bus.rsp_valid, 1);
        check_val("ws_n6_err",   bus.rsp_err,   1);
        check_val("ws_n6_rdata", bus.rsp_rdata, 0);
        step();
        check_val("ws_n7_rspv",  bus.rsp_valid, 0);
        check_val("ws_err_hold", bus.rsp_err,   1);

        // ---------------- timeout abort on a read ----------------
        tb_pready = 1'b0;
        issue(1'b0, 8'h04, 32'h0);
        step();
        bus.cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("to_wait_rspv", bus.rsp_valid, 0);
            check_val("to_wait_psel", bus.PSEL,      1);
        end
        step();
        check_val("to_rspv",    bus.rsp_valid, 1);
        check_val("to_err",     bus.rsp_err,   1);
        check_val("to_rdata",   bus.rsp_rdata, 0);
        check_val("to_psel",    bus.PSEL,      0);
        check_val("to_penable", bus.PENABLE,   0);

        // ---------------- ready arriving exactly at the limit ----------------
        issue(1'b0, 8'h04, 32'h0);
        step();
        bus.cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("lim_wait_rspv", bus.rsp_valid, 0);
        end
        tb_pready = 1'b1;
        step();
        check_val("lim_rspv",  bus.rsp_valid, 1);
        check_val("lim_err",   bus.rsp_err,   0);
        check_val("lim_rdata", bus.rsp_rdata, 32'h0000_1234);

        // ---------------- back-to-back writes, cmd_valid held ----------------
        k = 0;
        n_rsp = 0;
        issue(1'b1, 8'h00, 32'h11);
        for (int cyc = 0; cyc < 12; cyc++) begin
            will_acc = bus.cmd_valid && bus.cmd_ready;
            step();
            if (will_acc) begin
                if (k < 3) acc_cyc[k] = cyc;
                k++;
                if (k == 1)      issue(1'b1, 8'h00, 32'h22);
                else if (k == 2) issue(1'b1, 8'h00, 32'h33);
                else             bus.cmd_valid = 1'b0;
            end
            if (bus.rsp_valid) begin
                if (n_rsp < 3) rsp_cyc[n_rsp] = cyc;
                n_rsp++;
            end
        end
        check_val("b2b_accepts", k,          3);
        check_val("b2b_rsps",    n_rsp,      3);
        check_val("b2b_acc0",    acc_cyc[0], 0);
        check_val("b2b_acc1",    acc_cyc[1], 3);
        check_val("b2b_acc2",    acc_cyc[2], 6);
        check_val("b2b_rsp0",    rsp_cyc[0], 2);
        check_val("b2b_rsp1",    rsp_cyc[1], 5);
        check_val("b2b_rsp2",    rsp_cyc[2], 8);
        check_val("b2b_led",     led,        32'h33);

        // ---------------- reset during ACCESS ----------------
        tb_pready = 1'b0;
        issue(1'b1, 8'h00, 32'h55);
        step();
        bus.cmd_valid = 1'b0;
        step();
        check_val("mr_penable_pre", bus.PENABLE, 1);
        #2;
        PRESETn = 1'b0;
        #1;
        check_val("mr_psel",    bus.PSEL,      0);
        check_val("mr_penable", bus.PENABLE,   0);
        check_val("mr_rspv",    bus.rsp_valid, 0);
        step();
        PRESETn   = 1'b1;
        tb_pready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("mr_no_rsp", bus.rsp_valid, 0);
        end
        check_val("mr_ready", bus.cmd_ready, 1);
        check_val("mr_led",   led,           32'h33);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
